bcd_display_mux: RTL

- Downstream consumer of the BCD counter digit outputs.
- Captures a packed multi-digit BCD word on a load strobe and drives a time-multiplexed seven-segment display: per-digit anode select, segment decode and decimal point.
- Also provides leading-zero blanking, a dash glyph for invalid nibbles, and a once-per-frame strobe.

---
 rtl/bcd_display_mux.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/bcd_display_mux.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_display_mux
//  Description : Captures a packed multi-digit BCD word on a load strobe and
//                drives a time-multiplexed seven-segment display. Each digit
//                gets a slot of REFRESH_DIV clocks. The first clock of a slot
//                is a blank guard cycle with every anode off. The block also
//                provides leading-zero blanking, a dash glyph for nibbles
//                above 9, a sticky error flag for such nibbles, and a
//                one-cycle strobe each time the scan returns to digit 0.
//
//  Ports       : clk        - system clock, rising edge
//                rst        - synchronous active-high reset
//                load       - capture bcd_in / dp_in on this edge
//                bcd_in     - packed BCD word, digit 0 in bits [3:0]
//                dp_in      - decimal point request per digit
//                seg        - segments {g,f,e,d,c,b,a}
//                dp         - decimal point of the active digit
//                an         - one-hot anode enable
//                frame_done - one-cycle pulse after the scan wraps to digit 0
//                err        - sticky flag: a loaded nibble was above 9
//
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_display_mux #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done,
    output logic                    err
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int C_PW = $clog2(REFRESH_DIV);
    localparam int C_IW = $clog2(NUM_DIGITS);

    localparam logic [C_PW-1:0] C_PRESC_LAST = C_PW'(REFRESH_DIV - 1);
    localparam logic [C_IW-1:0] C_IDX_LAST   = C_IW'(NUM_DIGITS - 1);

    // XOR masks that convert active-high values to the pin polarity. The
    // inactive pin level is therefore the mask itself.
    localparam logic [6:0]            C_SEG_POL = {7{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] C_AN_POL  = {NUM_DIGITS{SEG_ACTIVE_LOW}};
    localparam logic                  C_DP_POL  = SEG_ACTIVE_LOW;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [4*NUM_DIGITS-1:0] r_shadow_q,     w_shadow_d;
    logic [NUM_DIGITS-1:0]   r_dp_shadow_q,  w_dp_shadow_d;
    logic [C_PW-1:0]         r_presc_q,      w_presc_d;
    logic [C_IW-1:0]         r_idx_q,        w_idx_d;
    logic                    r_err_q,        w_err_d;
    logic                    r_frame_done_q, w_frame_done_d;
    logic [6:0]              r_seg_q,        w_seg_d;
    logic                    r_dp_q,         w_dp_d;
    logic [NUM_DIGITS-1:0]   r_an_q,         w_an_d;

    // ------------------------------------------------------------------------
    // Per-digit views of the shadow word and of the incoming word
    // ------------------------------------------------------------------------
    logic [3:0]            w_digit [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] w_zero;       // digit is 0 with no dp request
    logic [NUM_DIGITS-1:0] w_blank;      // digit is a leading zero
    logic [NUM_DIGITS-1:0] w_in_bad;     // incoming nibble above 9

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        assign w_digit[k]  = r_shadow_q[4*k +: 4];
        assign w_zero[k]   = (r_shadow_q[4*k +: 4] == 4'd0) && !r_dp_shadow_q[k];
        assign w_in_bad[k] = (bcd_in[4*k +: 4] > 4'd9);
    end

    // A digit is a leading zero when it and every digit above it are zero.
    // The chain runs from the top digit down; digit 0 is always shown.
    assign w_blank[NUM_DIGITS-1] = w_zero[NUM_DIGITS-1];
    for (genvar k = 1; k < NUM_DIGITS - 1; k++) begin : g_blank
        assign w_blank[k] = w_zero[k] && w_blank[k+1];
    end
    assign w_blank[0] = 1'b0;

    // ------------------------------------------------------------------------
    // Seven-segment decode, active-high {g,f,e,d,c,b,a}
    // ------------------------------------------------------------------------
    function automatic logic [6:0] f_decode(input logic [3:0] val);
        logic [6:0] v_seg;
        case (val)
            4'd0:    v_seg = 7'b0111111;
            4'd1:    v_seg = 7'b0000110;
            4'd2:    v_seg = 7'b1011011;
            4'd3:    v_seg = 7'b1001111;
            4'd4:    v_seg = 7'b1100110;
            4'd5:    v_seg = 7'b1101101;
            4'd6:    v_seg = 7'b1111101;
            4'd7:    v_seg = 7'b0000111;
            4'd8:    v_seg = 7'b1111111;
            4'd9:    v_seg = 7'b1101111;
            default: v_seg = 7'b1000000;   // dash for non-BCD values
        endcase
        return v_seg;
    endfunction

    // ------------------------------------------------------------------------
    // Scan control and current-digit selection
    // ------------------------------------------------------------------------
    logic                  w_presc_wrap;
    logic                  w_idx_wrap;
    logic                  w_guard;
    logic [3:0]            w_cur_digit;
    logic                  w_cur_blank;
    logic                  w_cur_dp;
    logic [NUM_DIGITS-1:0] w_onehot;

    assign w_presc_wrap = (r_presc_q == C_PRESC_LAST);
    assign w_idx_wrap   = w_presc_wrap && (r_idx_q == C_IDX_LAST);
    assign w_guard      = (r_presc_q == '0);
    assign w_cur_digit  = w_digit[r_idx_q];
    assign w_cur_blank  = w_blank[r_idx_q];
    assign w_cur_dp     = r_dp_shadow_q[r_idx_q];
    assign w_onehot     = NUM_DIGITS'(1) << r_idx_q;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_shadow_d     = r_shadow_q;
        w_dp_shadow_d  = r_dp_shadow_q;
        w_err_d        = r_err_q;
        w_presc_d      = r_presc_q + C_PW'(1);
        w_idx_d        = r_idx_q;
        w_frame_done_d = w_idx_wrap;
        w_seg_d        = C_SEG_POL;
        w_dp_d         = C_DP_POL;
        w_an_d         = C_AN_POL;

        if (w_presc_wrap) begin
            w_presc_d = '0;
            w_idx_d   = (r_idx_q == C_IDX_LAST) ? '0 : r_idx_q + C_IW'(1);
        end

        if (load) begin
            w_shadow_d    = bcd_in;
            w_dp_shadow_d = dp_in;
            if (|w_in_bad) begin
                w_err_d = 1'b1;
            end
        end

        // Outputs come from the current (pre-edge) scan position and shadow,
        // so a load only becomes visible one edge after it is captured.
        if (!w_cur_blank) begin
            w_seg_d = f_decode(w_cur_digit) ^ C_SEG_POL;
            w_dp_d  = w_cur_dp ^ C_DP_POL;
            if (!w_guard) begin
                w_an_d = w_onehot ^ C_AN_POL;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow_q     <= '0;
            r_dp_shadow_q  <= '0;
            r_presc_q      <= '0;
            r_idx_q        <= '0;
            r_err_q        <= 1'b0;
            r_frame_done_q <= 1'b0;
            r_seg_q        <= C_SEG_POL;
            r_dp_q         <= C_DP_POL;
            r_an_q         <= C_AN_POL;
        end else begin
            r_shadow_q     <= w_shadow_d;
            r_dp_shadow_q  <= w_dp_shadow_d;
            r_presc_q      <= w_presc_d;
            r_idx_q        <= w_idx_d;
            r_err_q        <= w_err_d;
            r_frame_done_q <= w_frame_done_d;
            r_seg_q        <= w_seg_d;
            r_dp_q         <= w_dp_d;
            r_an_q         <= w_an_d;
        end
    end

    assign seg        = r_seg_q;
    assign dp         = r_dp_q;
    assign an         = r_an_q;
    assign frame_done = r_frame_done_q;
    assign err        = r_err_q;

endmodule
`default_nettype wire
